systolic_mac_pe: RTL and testbench
==================================

Name: systolic_mac_pe

Overview:
- Second-generation processing element for the brightness-filter systolic array.
- Adds four things: a weight-stationary mode with shift-chain weight loading, selectable signed arithmetic, an optional multiplier pipeline stage, and saturating accumulation with a sticky overflow flag.
- Valid flags travel with the data and partial sums.
- Tiles in a 2-D grid: data moves east, weights move south, partial sums move south.

Parameters:
- DATA_W, 8, pixel/data operand width.
- WT_W, 8, weight operand width.
- ACC_W, 32, partial-sum width; must be >= DATA_W+WT_W+1 (elaboration error otherwise).
- MULT_PIPE, 0, number of register stages after the multiplier; legal values are 0 or 1.
- SIGNED, 0, 1 = operands and accumulator are two's complement; 0 = unsigned.
- SAT_EN, 1, 1 = clamp the accumulator on overflow; 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  clock enable; 0 freezes every register.
- mode  in  1  0 = weight-stationary, 1 = weight-streaming (product uses wt_in directly).
- wt_load  in  1  mode 0 only: capture wt_in into the stationary weight register.
- clear_sat  in  1  synchronous clear of sat_flag.
- data_in  in  DATA_W  operand from the west neighbour.
- data_valid_in  in  1  qualifies data_in.
- wt_in  in  WT_W  weight from the north neighbour.
- acc_in  in  ACC_W  partial sum from the north neighbour.
- data_out  out  DATA_W  registered data_in, to the east.
- data_valid_out  out  1  registered data_valid_in.
- wt_out  out  WT_W  registered wt_in, to the south (both modes).
- acc_out  out  ACC_W  registered partial sum, to the south.
- acc_valid_out  out  1  acc_out holds a result that included a valid product.
- sat_flag  out  1  sticky: set once any saturation has occurred.

Behaviour:
- Reset (reset=0, async): all outputs, the weight register, the pipeline registers and sat_flag go to 0 immediately. In-flight operations are discarded. Outputs stay at 0 until the first enabled edge after reset deasserts.
- en=0: every register holds, including the pipeline stage and sat_flag. wt_load and clear_sat are ignored.
- Forwarding (en=1): data_out, data_valid_out and wt_out take their inputs with 1-cycle latency, independent of MULT_PIPE.
- Weight select:
  - mode 0: weight = weight register.
  - mode 1: weight = wt_in of the same cycle.
- Weight register update:
  - Loads wt_in when en=1, mode=0 and wt_load=1.
  - Holds otherwise, including across mode changes.
- Load/compute collision: if wt_load=1 and data_valid_in=1 in the same cycle, the product uses the old weight. The new weight is used from the next cycle.
- Product:
  - Full width, DATA_W+WT_W bits.
  - Sign-extended to ACC_W if SIGNED=1, zero-extended otherwise.
  - Forced to 0 when data_valid_in=0, so acc_in passes through unchanged.
- Sum: acc_in + product, computed in ACC_W+1 bits.
- Overflow detection:
  - Unsigned: carry out of the ACC_W-bit addition.
  - Signed: operands have equal signs and the result sign differs.
- SAT_EN=1 on overflow:
  - Clamp to 2^ACC_W-1 (unsigned).
  - Clamp to +max or -min (signed), matching the sign of the operands.
  - sat_flag <= 1.
- SAT_EN=0: result wraps and sat_flag is never set.
- sat_flag: sticky. clear_sat=1 clears it on the next edge. If clear_sat and a new overflow occur in the same cycle, set wins.
- Accumulator latency:
  - MULT_PIPE=0: acc_out and acc_valid_out are updated 1 cycle after the inputs.
  - MULT_PIPE=1: the product and its valid are registered first. acc_in is delayed one stage alongside them. acc_out appears 2 cycles after the inputs. The array applies a matching one-cycle extra skew on the partial-sum column.
- acc_valid_out = data_valid_in delayed by the accumulator latency. Its value is independent of acc_in.
- Mode switch: takes effect at the first edge where the new mode is sampled. In-flight pipeline data completes with the weight that was selected when it entered.
- Back-to-back valids: one result per cycle, no bubbles.

Test Plan:
- Defaults, mode=1, data_in=200, wt_in=3, acc_in=10, valid=1 -> next cycle acc_out=610, acc_valid_out=1, data_out=200, wt_out=3.
- mode=0, wt_load=1 with wt_in=5 and data_valid_in=1, data_in=4 in the same cycle (weight register previously 0) -> acc_out=acc_in (old weight 0). Next cycle data_in=4 -> acc_out=acc_in+20, and weight stays 5 after wt_load drops.
- SAT_EN=1, unsigned, acc_in=0xFFFFFF00, data_in=255, wt_in=255 -> acc_out=0xFFFFFFFF, sat_flag=1. Then clear_sat=1 with no overflow -> sat_flag=0. Repeat with SAT_EN=0 -> acc_out=0x0000FD01, sat_flag=0.
- SIGNED=1, data_in=-128 (0x80), wt_in=127, acc_in=-0x7FFFFFF0 -> clamps to 0x80000000, sat_flag=1.
- MULT_PIPE=1, stream valid for 3 cycles with data 1,2,3, wt=2, acc_in=0 -> acc_out reads 2,4,6 on cycles 2,3,4; data_out appears on cycles 1,2,3.
- Assert reset low mid-stream between edges -> all outputs 0 immediately and the pending pipeline result is never emitted. Separately, hold en=0 for 3 cycles -> outputs frozen, then resume with the correct next result.

Source files
------------

// File: rtl/systolic_mac_pe.sv
// systolic_mac_pe
// Multiply-accumulate processing element for the brightness-filter systolic
// array. Data moves east, weights and partial sums move south. The weight is
// either held in a stationary register (mode 0) or taken from wt_in as it
// streams past (mode 1). An optional register stage after the multiplier
// adds one cycle to the accumulator path. On overflow the result is either
// clamped, setting a sticky flag, or allowed to wrap.

module systolic_mac_pe #(
  parameter int DATA_W    = 8,
  parameter int WT_W      = 8,
  parameter int ACC_W     = 32,
  parameter int MULT_PIPE = 0,
  parameter int SIGNED    = 0,
  parameter int SAT_EN    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              mode,
  input  logic              wt_load,
  input  logic              clear_sat,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid_in,
  input  logic [WT_W-1:0]   wt_in,
  input  logic [ACC_W-1:0]  acc_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid_out,
  output logic [WT_W-1:0]   wt_out,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid_out,
  output logic              sat_flag
);

  localparam int  PROD_W   = DATA_W + WT_W;
  localparam bit  SIGNED_B = (SIGNED != 0);
  localparam bit  SAT_B    = (SAT_EN != 0);

  // Reject configurations the datapath cannot represent.
  if (ACC_W < PROD_W + 1) begin : g_bad_acc_w
    $error("systolic_mac_pe: ACC_W must be at least DATA_W+WT_W+1");
  end
  if ((MULT_PIPE != 0) && (MULT_PIPE != 1)) begin : g_bad_mult_pipe
    $error("systolic_mac_pe: MULT_PIPE must be 0 or 1");
  end

  logic [WT_W-1:0]   wt_reg_r;
  logic [WT_W-1:0]   weight_sel_s;
  logic [PROD_W-1:0] prod_s;
  logic [ACC_W-1:0]  prod_full_s;
  logic [ACC_W-1:0]  prod_gated_s;
  logic [ACC_W-1:0]  add_acc_s;
  logic [ACC_W-1:0]  add_prod_s;
  logic              add_valid_s;
  logic [ACC_W:0]    sum_s;
  logic              ovf_s;
  logic              sat_hit_s;
  logic [ACC_W-1:0]  result_s;

  // Choose the stationary weight or the streaming weight for this cycle.
  always_comb begin
    weight_sel_s = {WT_W{1'b0}};
    if (mode) begin
      weight_sel_s = wt_in;
    end else begin
      weight_sel_s = wt_reg_r;
    end
  end

  // Full-width product, extended to the accumulator width in the arithmetic's sense.
  if (SIGNED_B) begin : g_mul_signed
    logic signed [PROD_W-1:0] op_a_s;
    logic signed [PROD_W-1:0] op_b_s;
    assign op_a_s      = $signed({{WT_W{data_in[DATA_W-1]}}, data_in});
    assign op_b_s      = $signed({{DATA_W{weight_sel_s[WT_W-1]}}, weight_sel_s});
    assign prod_s      = op_a_s * op_b_s;
    assign prod_full_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
  end else begin : g_mul_unsigned
    logic [PROD_W-1:0] op_a_s;
    logic [PROD_W-1:0] op_b_s;
    assign op_a_s      = {{WT_W{1'b0}}, data_in};
    assign op_b_s      = {{DATA_W{1'b0}}, weight_sel_s};
    assign prod_s      = op_a_s * op_b_s;
    assign prod_full_s = {{(ACC_W-PROD_W){1'b0}}, prod_s};
  end

  // An invalid operand contributes nothing, so acc_in passes straight through.
  always_comb begin
    prod_gated_s = {ACC_W{1'b0}};
    if (data_valid_in) begin
      prod_gated_s = prod_full_s;
    end else begin
      prod_gated_s = {ACC_W{1'b0}};
    end
  end

  if (MULT_PIPE == 1) begin : g_pipe
    logic [ACC_W-1:0] prod_r;
    logic [ACC_W-1:0] acc_dly_r;
    logic             prod_valid_r;

    // Product stage: acc_in rides along so the adder sees matching operands.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        prod_r       <= {ACC_W{1'b0}};
        acc_dly_r    <= {ACC_W{1'b0}};
        prod_valid_r <= 1'b0;
      end else if (en) begin
        prod_r       <= prod_gated_s;
        acc_dly_r    <= acc_in;
        prod_valid_r <= data_valid_in;
      end
    end

    assign add_prod_s  = prod_r;
    assign add_acc_s   = acc_dly_r;
    assign add_valid_s = prod_valid_r;
  end else begin : g_no_pipe
    assign add_prod_s  = prod_gated_s;
    assign add_acc_s   = acc_in;
    assign add_valid_s = data_valid_in;
  end

  // Add with one guard bit and detect overflow for the selected arithmetic.
  always_comb begin
    sum_s = {1'b0, add_acc_s} + {1'b0, add_prod_s};
    ovf_s = 1'b0;
    if (SIGNED_B) begin
      ovf_s = (add_acc_s[ACC_W-1] == add_prod_s[ACC_W-1]) &&
              (sum_s[ACC_W-1] != add_acc_s[ACC_W-1]);
    end else begin
      ovf_s = sum_s[ACC_W];
    end
  end

  // Clamp toward the operands' sign on overflow when saturation is enabled.
  always_comb begin
    sat_hit_s = ovf_s && SAT_B;
    result_s  = sum_s[ACC_W-1:0];
    if (sat_hit_s) begin
      if (!SIGNED_B) begin
        result_s = {ACC_W{1'b1}};
      end else if (add_acc_s[ACC_W-1]) begin
        result_s = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        result_s = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      result_s = sum_s[ACC_W-1:0];
    end
  end

  // Output registers, stationary weight and sticky saturation flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out       <= {DATA_W{1'b0}};
      data_valid_out <= 1'b0;
      wt_out         <= {WT_W{1'b0}};
      acc_out        <= {ACC_W{1'b0}};
      acc_valid_out  <= 1'b0;
      sat_flag       <= 1'b0;
      wt_reg_r       <= {WT_W{1'b0}};
    end else if (en) begin
      data_out       <= data_in;
      data_valid_out <= data_valid_in;
      wt_out         <= wt_in;
      acc_out        <= result_s;
      acc_valid_out  <= add_valid_s;
      if (!mode && wt_load) begin
        wt_reg_r <= wt_in;
      end
      // A fresh overflow outranks a clear in the same cycle.
      if (sat_hit_s) begin
        sat_flag <= 1'b1;
      end else if (clear_sat) begin
        sat_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Directed testbench for systolic_mac_pe. Four instances share the same
// inputs: defaults, wrapping (SAT_EN=0), signed, and pipelined (MULT_PIPE=1).
module tb_systolic_mac_pe;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        mode;
  logic        wt_load;
  logic        clear_sat;
  logic [7:0]  data_in;
  logic        data_valid_in;
  logic [7:0]  wt_in;
  logic [31:0] acc_in;

  logic [7:0]  d_data_out, w_data_out, s_data_out, p_data_out;
  logic        d_dv_out, w_dv_out, s_dv_out, p_dv_out;
  logic [7:0]  d_wt_out, w_wt_out, s_wt_out, p_wt_out;
  logic [31:0] d_acc_out, w_acc_out, s_acc_out, p_acc_out;
  logic        d_av_out, w_av_out, s_av_out, p_av_out;
  logic        d_sat, w_sat, s_sat, p_sat;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  systolic_mac_pe u_dflt (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .wt_load(wt_load),
    .clear_sat(clear_sat), .data_in(data_in), .data_valid_in(data_valid_in),
    .wt_in(wt_in), .acc_in(acc_in), .data_out(d_data_out),
    .data_valid_out(d_dv_out), .wt_out(d_wt_out), .acc_out(d_acc_out),
    .acc_valid_out(d_av_out), .sat_flag(d_sat));

  systolic_mac_pe #(.SAT_EN(0)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .wt_load(wt_load),
    .clear_sat(clear_sat), .data_in(data_in), .data_valid_in(data_valid_in),
    .wt_in(wt_in), .acc_in(acc_in), .data_out(w_data_out),
    .data_valid_out(w_dv_out), .wt_out(w_wt_out), .acc_out(w_acc_out),
    .acc_valid_out(w_av_out), .sat_flag(w_sat));

  systolic_mac_pe #(.SIGNED(1)) u_sgn (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .wt_load(wt_load),
    .clear_sat(clear_sat), .data_in(data_in), .data_valid_in(data_valid_in),
    .wt_in(wt_in), .acc_in(acc_in), .data_out(s_data_out),
    .data_valid_out(s_dv_out), .wt_out(s_wt_out), .acc_out(s_acc_out),
    .acc_valid_out(s_av_out), .sat_flag(s_sat));

  systolic_mac_pe #(.MULT_PIPE(1)) u_pipe (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .wt_load(wt_load),
    .clear_sat(clear_sat), .data_in(data_in), .data_valid_in(data_valid_in),
    .wt_in(wt_in), .acc_in(acc_in), .data_out(p_data_out),
    .data_valid_out(p_dv_out), .wt_out(p_wt_out), .acc_out(p_acc_out),
    .acc_valid_out(p_av_out), .sat_flag(p_sat));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input logic v, input logic [7:0] d,
                       input logic [7:0] w, input logic [31:0] a);
    mode = m; data_valid_in = v; data_in = d; wt_in = w; acc_in = a;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; wt_load = 1'b0; clear_sat = 1'b0;
    drive(1'b1, 1'b1, 8'd200, 8'd3, 32'd10);
    tick();
    n_checks++; if (d_acc_out !== 32'd0) begin n_errors++; $display("FAIL reset_acc: got %h expected 0", d_acc_out); end
    n_checks++; if (d_av_out !== 1'b0) begin n_errors++; $display("FAIL reset_acc_valid: got %b expected 0", d_av_out); end
    n_checks++; if (d_data_out !== 8'd0) begin n_errors++; $display("FAIL reset_data: got %h expected 0", d_data_out); end
    n_checks++; if (d_wt_out !== 8'd0) begin n_errors++; $display("FAIL reset_wt: got %h expected 0", d_wt_out); end
    n_checks++; if (d_dv_out !== 1'b0 || d_sat !== 1'b0) begin n_errors++; $display("FAIL reset_flags: got dv=%b sat=%b expected 0 0", d_dv_out, d_sat); end
    n_checks++; if (p_av_out !== 1'b0 || p_acc_out !== 32'd0) begin n_errors++; $display("FAIL reset_pipe: got av=%b acc=%h expected 0 0", p_av_out, p_acc_out); end
    reset = 1'b1;
  endtask

  task automatic test_stream();
    drive(1'b1, 1'b1, 8'd200, 8'd3, 32'd10);
    tick();
    n_checks++; if (d_acc_out !== 32'd610) begin n_errors++; $display("FAIL stream_acc: got %0d expected 610", d_acc_out); end
    n_checks++; if (d_av_out !== 1'b1) begin n_errors++; $display("FAIL stream_acc_valid: got %b expected 1", d_av_out); end
    n_checks++; if (d_data_out !== 8'd200 || d_dv_out !== 1'b1) begin n_errors++; $display("FAIL stream_data: got %0d/%b expected 200/1", d_data_out, d_dv_out); end
    n_checks++; if (d_wt_out !== 8'd3) begin n_errors++; $display("FAIL stream_wt: got %0d expected 3", d_wt_out); end
    n_checks++; if (p_data_out !== 8'd200 || p_av_out !== 1'b0) begin n_errors++; $display("FAIL stream_pipe_fwd: got data=%0d av=%b expected 200 0", p_data_out, p_av_out); end
  endtask

  task automatic test_weight_load();
    wt_load = 1'b1;
    drive(1'b0, 1'b1, 8'd4, 8'd5, 32'd100);
    tick();
    n_checks++; if (d_acc_out !== 32'd100) begin n_errors++; $display("FAIL wload_collision: got %0d expected 100", d_acc_out); end
    n_checks++; if (d_wt_out !== 8'd5) begin n_errors++; $display("FAIL wload_wt_out: got %0d expected 5", d_wt_out); end
    wt_load = 1'b0;
    drive(1'b0, 1'b1, 8'd4, 8'd9, 32'd100);
    tick();
    n_checks++; if (d_acc_out !== 32'd120) begin n_errors++; $display("FAIL wload_new_weight: got %0d expected 120", d_acc_out); end
    n_checks++; if (d_wt_out !== 8'd9) begin n_errors++; $display("FAIL wload_wt_fwd: got %0d expected 9", d_wt_out); end
    tick();
    n_checks++; if (d_acc_out !== 32'd120) begin n_errors++; $display("FAIL wload_hold: got %0d expected 120", d_acc_out); end
  endtask

  task automatic test_saturation();
    clear_sat = 1'b1;
    drive(1'b1, 1'b0, 8'd0, 8'd0, 32'd0);
    tick();
    clear_sat = 1'b0;
    drive(1'b1, 1'b1, 8'd255, 8'd255, 32'hFFFF_FF00);
    tick();
    n_checks++; if (d_acc_out !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL sat_clamp: got %h expected ffffffff", d_acc_out); end
    n_checks++; if (d_sat !== 1'b1) begin n_errors++; $display("FAIL sat_flag_set: got %b expected 1", d_sat); end
    n_checks++; if (w_acc_out !== 32'h0000_FD01) begin n_errors++; $display("FAIL wrap_value: got %h expected 0000fd01", w_acc_out); end
    n_checks++; if (w_sat !== 1'b0) begin n_errors++; $display("FAIL wrap_no_flag: got %b expected 0", w_sat); end
    clear_sat = 1'b1;
    tick();
    n_checks++; if (d_sat !== 1'b1) begin n_errors++; $display("FAIL sat_set_wins: got %b expected 1", d_sat); end
    drive(1'b1, 1'b0, 8'd255, 8'd255, 32'h1234_5678);
    tick();
    n_checks++; if (d_sat !== 1'b0) begin n_errors++; $display("FAIL sat_clear: got %b expected 0", d_sat); end
    n_checks++; if (d_acc_out !== 32'h1234_5678 || d_av_out !== 1'b0) begin n_errors++; $display("FAIL invalid_passthru: got %h/%b expected 12345678/0", d_acc_out, d_av_out); end
    clear_sat = 1'b0;
    drive(1'b1, 1'b1, 8'd255, 8'd255, 32'hFFFF_01FE);
    tick();
    n_checks++; if (d_acc_out !== 32'hFFFF_FFFF || d_sat !== 1'b0) begin n_errors++; $display("FAIL sat_edge_exact: got %h/%b expected ffffffff/0", d_acc_out, d_sat); end
  endtask

  task automatic test_signed();
    clear_sat = 1'b1;
    drive(1'b1, 1'b0, 8'd0, 8'd0, 32'd0);
    tick();
    clear_sat = 1'b0;
    drive(1'b1, 1'b1, 8'h80, 8'h7F, 32'h8000_0010);
    tick();
    n_checks++; if (s_acc_out !== 32'h8000_0000) begin n_errors++; $display("FAIL signed_neg_clamp: got %h expected 80000000", s_acc_out); end
    n_checks++; if (s_sat !== 1'b1) begin n_errors++; $display("FAIL signed_sat_flag: got %b expected 1", s_sat); end
    drive(1'b1, 1'b1, 8'h7F, 8'h7F, 32'h7FFF_FF00);
    tick();
    n_checks++; if (s_acc_out !== 32'h7FFF_FFFF) begin n_errors++; $display("FAIL signed_pos_clamp: got %h expected 7fffffff", s_acc_out); end
    clear_sat = 1'b1;
    drive(1'b1, 1'b1, 8'hFD, 8'h05, 32'd100);
    tick();
    n_checks++; if (s_acc_out !== 32'd85) begin n_errors++; $display("FAIL signed_normal: got %0d expected 85", s_acc_out); end
    n_checks++; if (s_sat !== 1'b0) begin n_errors++; $display("FAIL signed_clear: got %b expected 0", s_sat); end
    clear_sat = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_acc [6];
    logic        exp_av  [6];
    logic [7:0]  exp_dat [6];
    logic [31:0] acc_seq [3];
    exp_acc = '{32'd0, 32'd2, 32'd104, 32'd6, 32'd0, 32'd0};
    exp_av  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_dat = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0};
    acc_seq = '{32'd0, 32'd100, 32'd0};
    drive(1'b1, 1'b0, 8'd0, 8'd2, 32'd0);
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive(1'b1, 1'b1, 8'(i + 1), 8'd2, acc_seq[i]);
      else       drive(1'b1, 1'b0, 8'd0, 8'd2, 32'd0);
      tick();
      n_checks++; if (p_acc_out !== exp_acc[i] || p_av_out !== exp_av[i]) begin n_errors++; $display("FAIL pipe_acc_c%0d: got %0d/%b expected %0d/%b", i + 1, p_acc_out, p_av_out, exp_acc[i], exp_av[i]); end
      n_checks++; if (p_data_out !== exp_dat[i]) begin n_errors++; $display("FAIL pipe_data_c%0d: got %0d expected %0d", i + 1, p_data_out, exp_dat[i]); end
      if (i == 0) begin
        n_checks++; if (d_acc_out !== 32'd2) begin n_errors++; $display("FAIL nopipe_latency: got %0d expected 2", d_acc_out); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 1'b1, 8'd7, 8'd3, 32'd50);
    tick();
    #2 reset = 1'b0;
    #1;
    n_checks++; if (p_acc_out !== 32'd0 || p_av_out !== 1'b0 || p_data_out !== 8'd0) begin n_errors++; $display("FAIL midreset_pipe: got %h/%b/%h expected 0", p_acc_out, p_av_out, p_data_out); end
    n_checks++; if (d_acc_out !== 32'd0 || d_data_out !== 8'd0 || d_wt_out !== 8'd0) begin n_errors++; $display("FAIL midreset_dflt: got %h/%h/%h expected 0", d_acc_out, d_data_out, d_wt_out); end
    drive(1'b1, 1'b0, 8'd0, 8'd0, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (p_acc_out !== 32'd0 || p_av_out !== 1'b0) begin n_errors++; $display("FAIL midreset_discard: got %h/%b expected 0/0", p_acc_out, p_av_out); end
  endtask

  task automatic test_enable();
    drive(1'b1, 1'b1, 8'd1, 8'd1, 32'hFFFF_FFFF);
    tick();
    drive(1'b1, 1'b1, 8'd10, 8'd10, 32'd5);
    tick();
    n_checks++; if (d_acc_out !== 32'd105 || d_sat !== 1'b1) begin n_errors++; $display("FAIL en_pre: got %0d/%b expected 105/1", d_acc_out, d_sat); end
    en = 1'b0; wt_load = 1'b1; clear_sat = 1'b1;
    drive(1'b0, 1'b1, 8'd1, 8'd7, 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (d_acc_out !== 32'd105 || d_data_out !== 8'd10 || d_wt_out !== 8'd10 || d_sat !== 1'b1) begin n_errors++; $display("FAIL en_freeze_c%0d: got %0d/%0d/%0d/%b expected 105/10/10/1", c, d_acc_out, d_data_out, d_wt_out, d_sat); end
      n_checks++; if (p_acc_out !== 32'hFFFF_FFFF || p_av_out !== 1'b1) begin n_errors++; $display("FAIL en_freeze_pipe_c%0d: got %h/%b expected ffffffff/1", c, p_acc_out, p_av_out); end
    end
    en = 1'b1; wt_load = 1'b0; clear_sat = 1'b0;
    drive(1'b1, 1'b1, 8'd6, 8'd7, 32'd1);
    tick();
    n_checks++; if (d_acc_out !== 32'd43 || d_sat !== 1'b1) begin n_errors++; $display("FAIL en_resume: got %0d/%b expected 43/1", d_acc_out, d_sat); end
    n_checks++; if (p_acc_out !== 32'd105) begin n_errors++; $display("FAIL en_resume_pipe: got %0d expected 105", p_acc_out); end
    drive(1'b0, 1'b1, 8'd1, 8'd9, 32'd3);
    tick();
    n_checks++; if (d_acc_out !== 32'd3) begin n_errors++; $display("FAIL en_load_ignored: got %0d expected 3", d_acc_out); end
    n_checks++; if (p_acc_out !== 32'd43) begin n_errors++; $display("FAIL en_pipe_next: got %0d expected 43", p_acc_out); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_weight_load();
    test_saturation();
    test_signed();
    test_back_to_back();
    test_reset_midstream();
    test_enable();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
